// File: rtl/bp_me_cache_port_arbiter.sv
// Round-robin arbiter that shares one bsg_cache packet port among several
// requesters. Multi-beat bursts keep the grant until their last beat. Cache
// responses return in order and go back to the issuing requester through an
// ID FIFO.
module bp_me_cache_port_arbiter #(
    parameter int num_req_p         = 2,
    parameter int pkt_width_p       = 64,
    parameter int data_width_p      = 64,
    parameter int max_outstanding_p = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p*pkt_width_p-1:0] pkt_i,
    input  logic [num_req_p-1:0]             pkt_v_i,
    input  logic [num_req_p-1:0]             pkt_last_i,
    output logic [num_req_p-1:0]             pkt_ready_and_o,
    output logic [pkt_width_p-1:0]           cache_pkt_o,
    output logic                             cache_v_o,
    input  logic                             cache_ready_i,
    input  logic [data_width_p-1:0]          cache_data_i,
    input  logic                             cache_v_i,
    output logic                             cache_yumi_o,
    output logic [data_width_p-1:0]          data_o,
    output logic [num_req_p-1:0]             v_o,
    input  logic [num_req_p-1:0]             yumi_i
);

    localparam int id_w_lp  = $clog2(num_req_p);
    localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e              state_r, state_n;
    logic [id_w_lp-1:0]  rr_ptr_r, rr_ptr_n;
    logic [id_w_lp-1:0]  owner_r, owner_n;
    logic [id_w_lp-1:0]  gnt;
    logic                found;
    logic [31:0]         idx;

    logic [id_w_lp-1:0]  ids_r [max_outstanding_p];
    logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
    logic [cnt_w_lp-1:0] count_r, count_n;
    logic                fifo_full_r;
    logic                fifo_v;
    logic [id_w_lp-1:0]  head;
    logic                push, pop;

    assign fifo_v = (count_r != '0);
    assign head   = ids_r[rd_ptr_r];
    assign data_o = cache_data_i;

    // Grant selection: owner while locked, otherwise first valid from rr_ptr.
    always_comb begin
        gnt   = rr_ptr_r;
        found = 1'b0;
        idx   = '0;
        if (state_r == LOCKED) begin
            gnt = owner_r;
        end else begin
            for (int unsigned j = 0; j < num_req_p; j++) begin
                idx = (32'(rr_ptr_r) + j) % num_req_p;
                if (!found && pkt_v_i[idx[id_w_lp-1:0]]) begin
                    found = 1'b1;
                    gnt   = idx[id_w_lp-1:0];
                end
            end
        end
    end

    // Packet-side handshakes; forced low while reset is held so the outputs
    // drop immediately even though cache_ready_i/pkt_v_i may still be high.
    always_comb begin
        pkt_ready_and_o = '0;
        cache_v_o       = 1'b0;
        cache_pkt_o     = pkt_i[gnt*pkt_width_p +: pkt_width_p];
        if (!reset_i) begin
            pkt_ready_and_o[gnt] = cache_ready_i & ~fifo_full_r;
            cache_v_o            = pkt_v_i[gnt] & ~fifo_full_r;
        end
    end

    // Response routing to the requester at the head of the ID FIFO.
    always_comb begin
        v_o          = '0;
        cache_yumi_o = 1'b0;
        if (!reset_i && fifo_v) begin
            v_o[head]    = cache_v_i;
            cache_yumi_o = yumi_i[head];
        end
    end

    assign push = cache_v_o & cache_ready_i;
    assign pop  = cache_yumi_o;

    // Next-state: lock on a non-last beat, unlock and advance rr_ptr on a last beat.
    always_comb begin
        state_n  = state_r;
        rr_ptr_n = rr_ptr_r;
        owner_n  = owner_r;
        if (push) begin
            if (pkt_last_i[gnt]) begin
                state_n  = IDLE;
                rr_ptr_n = (gnt == id_w_lp'(num_req_p - 1)) ? '0 : gnt + id_w_lp'(1);
            end else begin
                state_n = LOCKED;
                owner_n = gnt;
            end
        end
    end

    // Outstanding-beat count after this cycle's push/pop.
    always_comb begin
        count_n = count_r;
        if (push && !pop)      count_n = count_r + cnt_w_lp'(1);
        else if (!push && pop) count_n = count_r - cnt_w_lp'(1);
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
        end else begin
            state_r  <= state_n;
            rr_ptr_r <= rr_ptr_n;
            owner_r  <= owner_n;
        end
    end

    // ID FIFO storage, pointers and registered full flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned k = 0; k < max_outstanding_p; k++) ids_r[k] <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            fifo_full_r <= 1'b0;
        end else begin
            if (push) begin
                ids_r[wr_ptr_r] <= gnt;
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : wr_ptr_r + ptr_w_lp'(1);
            end
            if (pop) begin
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : rd_ptr_r + ptr_w_lp'(1);
            end
            count_r     <= count_n;
            fifo_full_r <= (count_n == cnt_w_lp'(max_outstanding_p));
        end
    end

    // A response with nothing outstanding indicates an upstream protocol bug.
    always_ff @(posedge clk_i) begin
        if (!reset_i && cache_v_i && !fifo_v)
            $error("cache response received with no outstanding request");
    end

endmodule

// File: tb/tb_bp_me_cache_port_arbiter.sv
// Randomized bench for bp_me_cache_port_arbiter against a queue-based model.
module tb_bp_me_cache_port_arbiter;

    localparam int N  = 3;
    localparam int PW = 16;
    localparam int DW = 32;
    localparam int MO = 4;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [N*PW-1:0] pkt_i;
    logic [N-1:0]    pkt_v_i, pkt_last_i, pkt_ready_and_o;
    logic [PW-1:0]   cache_pkt_o;
    logic            cache_v_o, cache_ready_i;
    logic [DW-1:0]   cache_data_i, data_o;
    logic            cache_v_i, cache_yumi_o;
    logic [N-1:0]    v_o, yumi_i;

    bp_me_cache_port_arbiter #(
        .num_req_p(N), .pkt_width_p(PW), .data_width_p(DW), .max_outstanding_p(MO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .pkt_i(pkt_i), .pkt_v_i(pkt_v_i), .pkt_last_i(pkt_last_i),
        .pkt_ready_and_o(pkt_ready_and_o),
        .cache_pkt_o(cache_pkt_o), .cache_v_o(cache_v_o), .cache_ready_i(cache_ready_i),
        .cache_data_i(cache_data_i), .cache_v_i(cache_v_i), .cache_yumi_o(cache_yumi_o),
        .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: outstanding IDs in issue order, burst owner (-1 = none), rr pointer.
    int q[$];
    int owner = -1;
    int rr    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare this cycle's outputs, then advance the model as of the coming edge.
    task automatic model_cycle();
        int           gnt;
        logic         full;
        logic         acc;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_v;
        logic         exp_yumi;
        gnt  = -1;
        full = (q.size() == MO);
        if (owner >= 0) begin
            if (pkt_v_i[owner]) gnt = owner;
        end else begin
            for (int k = 0; k < N; k++)
                if (gnt < 0 && pkt_v_i[(rr + k) % N]) gnt = (rr + k) % N;
        end
        exp_rdy = '0;
        if (gnt >= 0 && cache_ready_i && !full) exp_rdy[gnt] = 1'b1;
        check_eq("ready", 64'(pkt_ready_and_o & pkt_v_i), 64'(exp_rdy));
        check_eq("cache_v", 64'(cache_v_o), 64'(gnt >= 0 && !full));
        if (gnt >= 0) check_eq("cache_pkt", 64'(cache_pkt_o), 64'(pkt_i[gnt*PW +: PW]));
        exp_v    = '0;
        exp_yumi = 1'b0;
        if (q.size() > 0) begin
            if (cache_v_i) exp_v[q[0]] = 1'b1;
            exp_yumi = yumi_i[q[0]];
        end
        check_eq("v_o", 64'(v_o), 64'(exp_v));
        check_eq("cache_yumi", 64'(cache_yumi_o), 64'(exp_yumi));
        check_eq("data", 64'(data_o), 64'(cache_data_i));
        acc = (gnt >= 0) && !full && cache_ready_i;
        if (exp_yumi) void'(q.pop_front());
        if (acc) begin
            q.push_back(gnt);
            if (pkt_last_i[gnt]) begin
                rr    = (gnt + 1) % N;
                owner = -1;
            end else begin
                owner = gnt;
            end
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        model_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_pkts();
        for (int i = 0; i < N; i++) pkt_i[i*PW +: PW] = PW'($urandom);
        cache_data_i = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 64'(pkt_ready_and_o), 64'(0));
        check_eq({tag, "_cache_v"}, 64'(cache_v_o), 64'(0));
        check_eq({tag, "_v_o"}, 64'(v_o), 64'(0));
        check_eq({tag, "_yumi"}, 64'(cache_yumi_o), 64'(0));
    endtask

    task automatic reset_model();
        q.delete();
        owner = -1;
        rr    = 0;
    endtask

    initial begin
        reset_i       = 1'b1;
        pkt_v_i       = '1;
        pkt_last_i    = '1;
        cache_ready_i = 1'b1;
        cache_v_i     = 1'b0;
        yumi_i        = '1;
        pkt_i         = '0;
        cache_data_i  = '0;
        #2;
        check_reset_outputs("por");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        reset_model();

        // Single-beat requests from everyone with no responses: rotate then fill.
        pkt_v_i    = '1;
        pkt_last_i = '1;
        yumi_i     = '0;
        for (int c = 0; c < 7; c++) begin
            rand_pkts();
            step();
        end

        // Drain in order, one pop per cycle.
        pkt_v_i = '0;
        for (int c = 0; c < 8; c++) begin
            rand_pkts();
            cache_v_i = (q.size() > 0);
            yumi_i    = '1;
            step();
        end
        cache_v_i = 1'b0;

        // Start a burst, build up outstanding beats, then reset mid-flight.
        pkt_v_i    = '1;
        pkt_last_i = '0;
        yumi_i     = '0;
        for (int c = 0; c < 3; c++) begin
            rand_pkts();
            step();
        end
        cache_v_i = (q.size() > 0);
        yumi_i    = '1;
        #2 reset_i = 1'b1;
        #1;
        check_reset_outputs("async");
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        reset_model();
        cache_v_i = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rand_pkts();
            for (int i = 0; i < N; i++) begin
                pkt_v_i[i]    = ($urandom_range(0, 3) != 0);
                pkt_last_i[i] = ($urandom_range(0, 3) == 0);
            end
            cache_ready_i = ($urandom_range(0, 4) != 0);
            cache_v_i     = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            yumi_i        = N'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
